shift_reg_seq: RTL and testbench

Initiator-side sequencer for the systolic-array shift_reg row/column buffer.
- Accepts burst commands.
- Streams words in via REG_WRITE.
- Drains words out via REG_READ into a valid/ready stream.
- Pulses REG_LOAD.
- Sits between the array controller / DMA streams and one shift_reg instance, and owns its ctrl_code and data_write pins.

---
 rtl/shift_reg_pkg.sv | 25 ++
 rtl/seq_out_fifo.sv | 48 ++++
 rtl/shift_reg_seq.sv | 151 +++++++++++++++
 tb/tb_shift_reg_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift_reg sequencer: shift_reg control codes,
// command opcodes, FSM states and output FIFO depth.
package shift_reg_pkg;

  localparam logic [1:0] REG_UPLOAD = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_WRITE  = 2'd2;
  localparam logic [1:0] REG_READ   = 2'd3;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'd0,
    CMD_READ  = 2'd1,
    CMD_LOAD  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_op_e;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_RD       = 3'd2;
  localparam logic [2:0] ST_RD_DRAIN = 3'd3;
  localparam logic [2:0] ST_LD       = 3'd4;

  localparam int OUT_DEPTH = 4;

endpackage

// File: rtl/seq_out_fifo.sv
// Four-entry synchronous FIFO holding read-burst words plus their last flag.
module seq_out_fifo
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [2:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [OUT_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != 3'(OUT_DEPTH));
  assign do_pop  = pop && (count != 3'd0);
  assign head    = mem[rd_ptr];
  assign empty   = (count == 3'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Initiator-side sequencer for one shift_reg: bursts words in via WRITE, drains
// them out via READ into a valid/ready stream, and pulses LOAD.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            reg_ctrl_code,
  output logic [DATA_WIDTH-1:0] reg_data_write,
  input  logic [DATA_WIDTH-1:0] reg_data_read,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(LENGTH + 1);

  logic [2:0]            state;
  logic [CW-1:0]         word_cnt;
  logic                  armed;
  logic                  done_q;
  logic [1:0]            ctrl_code_q;
  logic [DATA_WIDTH-1:0] data_write_q;
  // READ issue pipeline: p1 = READ code on the pins, p2 = data_read valid
  logic                  p1_vld, p1_last, p2_vld, p2_last;

  logic                  cmd_fire, s_fire, issue, issue_last, has_space;
  logic [3:0]            occupancy;
  logic [2:0]            fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;

  assign cmd_ready  = (state == ST_IDLE) && armed;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign s_ready    = (state == ST_WR);
  assign s_fire     = s_valid && s_ready;
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;
  assign reg_ctrl_code  = ctrl_code_q;
  assign reg_data_write = data_write_q;

  // In-flight reads reserve a FIFO slot so back-pressure can never drop a word
  assign occupancy  = {1'b0, fifo_count} + {3'b000, p1_vld} + {3'b000, p2_vld};
  assign has_space  = (occupancy < 4'(OUT_DEPTH));
  // The accepting cycle of a READ command already counts as the first issue
  assign issue      = (cmd_fire && (cmd_op == CMD_READ)) || ((state == ST_RD) && has_space);
  assign issue_last = (state == ST_RD) && (word_cnt == CW'(LENGTH - 1));

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_head[DATA_WIDTH-1:0];
  assign m_last  = fifo_head[DATA_WIDTH];

  seq_out_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (p2_vld),
    .push_data({p2_last, reg_data_read}),
    .pop      (m_valid && m_ready),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      word_cnt     <= '0;
      armed        <= 1'b0;
      done_q       <= 1'b0;
      ctrl_code_q  <= REG_UPLOAD;
      data_write_q <= '0;
      p1_vld       <= 1'b0;
      p1_last      <= 1'b0;
      p2_vld       <= 1'b0;
      p2_last      <= 1'b0;
    end else begin
      armed       <= 1'b1;
      done_q      <= 1'b0;
      ctrl_code_q <= issue ? REG_READ : REG_UPLOAD;
      p1_vld      <= issue;
      p1_last     <= issue && issue_last;
      p2_vld      <= p1_vld;
      p2_last     <= p1_last;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (cmd_op_e'(cmd_op))
              CMD_WRITE: begin
                state    <= ST_WR;
                word_cnt <= '0;
              end
              CMD_READ: begin
                state    <= ST_RD;
                word_cnt <= CW'(1);
              end
              CMD_LOAD: begin
                state       <= ST_LD;
                ctrl_code_q <= REG_LOAD;
                done_q      <= 1'b1;
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        ST_WR: begin
          if (s_fire) begin
            ctrl_code_q  <= REG_WRITE;
            data_write_q <= s_data;
            if (word_cnt == CW'(LENGTH - 1)) begin
              state    <= ST_IDLE;
              done_q   <= 1'b1;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end
        ST_RD: begin
          if (issue) begin
            if (issue_last) state <= ST_RD_DRAIN;
            word_cnt <= word_cnt + CW'(1);
          end
        end
        ST_RD_DRAIN: begin
          if (!p1_vld && !p2_vld && fifo_empty) begin
            state    <= ST_IDLE;
            done_q   <= 1'b1;
            word_cnt <= '0;
          end
        end
        ST_LD:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq with a behavioural shift_reg attached.
module tb_shift_reg_seq;
  localparam int DW  = 8;
  localparam int LEN = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [1:0]    reg_ctrl_code;
  logic [DW-1:0] reg_data_write;
  logic [DW-1:0] reg_data_read;
  logic          busy;
  logic          done;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  shift_reg_seq #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .reg_ctrl_code(reg_ctrl_code), .reg_data_write(reg_data_write),
    .reg_data_read(reg_data_read), .busy(busy), .done(done)
  );

  // Behavioural shift_reg: WRITE shifts toward index 0, READ rotates and registers contents[0]
  logic [DW-1:0] sr [LEN];
  logic [DW-1:0] sr_in [LEN];
  logic [DW-1:0] sr_rd;
  assign reg_data_read = sr_rd;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LEN; i++) sr[i] <= '0;
      sr_rd <= '0;
    end else begin
      case (reg_ctrl_code)
        2'd1: for (int i = 0; i < LEN; i++) sr[i] <= sr_in[i];
        2'd2: begin
          for (int i = 0; i < LEN - 1; i++) sr[i] <= sr[i+1];
          sr[LEN-1] <= reg_data_write;
        end
        2'd3: begin
          sr_rd <= sr[0];
          for (int i = 0; i < LEN - 1; i++) sr[i] <= sr[i+1];
          sr[LEN-1] <= sr[0];
        end
        default: ;
      endcase
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, s_ready, m_valid, m_last, m_data, reg_ctrl_code, reg_data_write, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b srdy=%b mv=%b ml=%b md=%h code=%0d dw=%h busy=%b done=%b exp all 0",
               cmd_ready, s_ready, m_valid, m_last, m_data, reg_ctrl_code, reg_data_write, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release got rdy/busy/done=%b exp 100", {cmd_ready, busy, done});
    end
  endtask

  // vmask bit c gives s_valid for the c-th cycle spent in WR
  task automatic test_write(input logic [4*DW-1:0] words, input logic [15:0] vmask, input logic hold_cmd);
    int k = 0;
    int c = 0;
    logic prev_acc = 1'b0;
    logic [DW-1:0] prev_d = '0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    while (k < LEN && c < 16) begin
      @(negedge clk);
      cmd_valid = hold_cmd;
      cmd_op    = 2'd2;
      vectors++;
      if ({reg_ctrl_code, done, busy, s_ready, cmd_ready} !== {(prev_acc ? 2'd2 : 2'd0), 4'b0110}) begin
        errors++;
        $display("FAIL wr_cycle%0d code/done/busy/srdy/crdy got %0d/%b exp %0d/0110", c,
                 reg_ctrl_code, {done, busy, s_ready, cmd_ready}, (prev_acc ? 2 : 0));
      end
      if (prev_acc) begin
        vectors++;
        if (reg_data_write !== prev_d) begin
          errors++;
          $display("FAIL wr_data%0d got %h exp %h", c, reg_data_write, prev_d);
        end
      end
      s_valid  = vmask[c];
      s_data   = s_valid ? words[k*DW +: DW] : 8'hEE;
      prev_acc = s_valid;
      prev_d   = s_data;
      if (s_valid) k++;
      if (k == LEN) cmd_valid = 1'b0;
      c++;
    end
    if (k < LEN) begin
      errors++;
      $display("FAIL wr_timeout accepted %0d exp %0d", k, LEN);
    end
    @(negedge clk);
    s_valid = 1'b0;
    vectors++;
    if ({reg_ctrl_code, reg_data_write, done, busy, s_ready} !== {2'd2, prev_d, 3'b100}) begin
      errors++;
      $display("FAIL wr_last code=%0d dw=%h done/busy/srdy=%b exp 2 %h 100",
               reg_ctrl_code, reg_data_write, {done, busy, s_ready}, prev_d);
    end
    @(negedge clk);
    vectors++;
    if ({reg_ctrl_code, done} !== 3'b000) begin
      errors++;
      $display("FAIL wr_after code=%0d done=%b exp 0 0", reg_ctrl_code, done);
    end
    for (int i = 0; i < LEN; i++) begin
      vectors++;
      if (sr[i] !== words[i*DW +: DW]) begin
        errors++;
        $display("FAIL wr_contents[%0d] got %h exp %h", i, sr[i], words[i*DW +: DW]);
      end
    end
  endtask

  // rmask bit (c%16) gives m_ready in cycle c after acceptance; full=1 also checks exact timing
  task automatic test_read(input logic [4*DW-1:0] words, input logic [15:0] rmask, input logic full);
    int n = 0;
    int first = -1;
    int reads = 0;
    logic done_seen = 1'b0;
    logic stalled = 1'b0;
    logic [DW:0] held = '0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_cmd_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    for (int c = 1; c < 60 && !done_seen; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (reg_ctrl_code == 2'd3) reads++;
      if (m_valid && first < 0) first = c;
      vectors++;
      if (dut.fifo_count > 3'd4) begin
        errors++;
        $display("FAIL rd_fifo_count got %0d exp <=4", dut.fifo_count);
      end
      if (stalled) begin
        vectors++;
        if ({m_valid, m_last, m_data} !== {1'b1, held}) begin
          errors++;
          $display("FAIL rd_stall_hold got v=%b l=%b d=%h exp 1 %b %h", m_valid, m_last, m_data, held[DW], held[DW-1:0]);
        end
      end
      if (done) begin
        done_seen = 1'b1;
        vectors++;
        if (n != LEN || (full && c != 8)) begin
          errors++;
          $display("FAIL rd_done_timing got words=%0d cycle=%0d exp %0d words%s", n, c, LEN, full ? " cycle=8" : "");
        end
      end
      m_ready = rmask[c % 16];
      if (m_valid && m_ready) begin
        vectors++;
        if (n >= LEN) begin
          errors++;
          $display("FAIL rd_extra_word got %h exp none", m_data);
        end else if ({m_last, m_data} !== {(n == LEN - 1), words[n*DW +: DW]} || (full && c != 3 + n)) begin
          errors++;
          $display("FAIL rd_word%0d got l=%b d=%h cycle=%0d exp l=%b d=%h", n, m_last, m_data, c,
                   (n == LEN - 1), words[n*DW +: DW]);
        end
        n++;
      end
      stalled = m_valid && !m_ready;
      held    = {m_last, m_data};
    end
    m_ready = 1'b0;
    if (!done_seen) begin
      errors++;
      $display("FAIL rd_timeout got words=%0d exp done", n);
    end
    vectors++;
    if (first != 3 || reads != LEN) begin
      errors++;
      $display("FAIL rd_first_valid/reads got %0d/%0d exp 3/%0d", first, reads, LEN);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, m_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rd_idle busy/done/mv got %b exp 000", {busy, done, m_valid});
    end
    for (int i = 0; i < LEN; i++) begin
      vectors++;
      if (sr[i] !== words[i*DW +: DW]) begin
        errors++;
        $display("FAIL rd_contents[%0d] got %h exp %h", i, sr[i], words[i*DW +: DW]);
      end
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < LEN; i++) sr_in[i] = 8'hA0 + 8'(i);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if ({reg_ctrl_code, done, busy} !== 4'b0111) begin
      errors++;
      $display("FAIL ld_pulse code=%0d done/busy=%b exp 1 11", reg_ctrl_code, {done, busy});
    end
    @(negedge clk);
    vectors++;
    if ({reg_ctrl_code, done, busy, cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL ld_after code=%0d done/busy/rdy=%b exp 0 001", reg_ctrl_code, {done, busy, cmd_ready});
    end
    for (int i = 0; i < LEN; i++) begin
      vectors++;
      if (sr[i] !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL ld_contents[%0d] got %h exp %h", i, sr[i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    s_valid   = 1'b1;
    s_data    = 8'h77;
    @(negedge clk);
    s_data = 8'h78;
    @(negedge clk);
    s_data  = 8'h79;
    reset_n = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    vectors++;
    if ({cmd_ready, s_ready, m_valid, reg_ctrl_code, reg_data_write, busy, done} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got rdy=%b srdy=%b mv=%b code=%0d dw=%h busy=%b done=%b exp all 0",
               cmd_ready, s_ready, m_valid, reg_ctrl_code, reg_data_write, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, done, sr[0], sr[1]} !== {3'b100, 16'h0000}) begin
      errors++;
      $display("FAIL rstmid_release rdy/busy/done=%b sr0=%h sr1=%h exp 100 00 00",
               {cmd_ready, busy, done}, sr[0], sr[1]);
    end
  endtask

  task automatic test_rsvd();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if ({reg_ctrl_code, done, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL rsvd_pulse code=%0d done/busy=%b exp 0 10", reg_ctrl_code, {done, busy});
    end
    @(negedge clk);
    vectors++;
    if ({reg_ctrl_code, done, busy, cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rsvd_after code=%0d done/busy/rdy=%b exp 0 001", reg_ctrl_code, {done, busy, cmd_ready});
    end
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) sr_in[i] = '0;
    test_reset();
    test_write({8'h44, 8'h33, 8'h22, 8'h11}, 16'hFFFF, 1'b0);
    test_read({8'h44, 8'h33, 8'h22, 8'h11}, 16'hFFFF, 1'b1);
    test_read({8'h44, 8'h33, 8'h22, 8'h11}, 16'b1001_0010_0100_1001, 1'b0);
    test_load();
    test_write({8'h64, 8'h63, 8'h62, 8'h61}, 16'h0065, 1'b1);
    test_reset_mid();
    test_write({8'h5D, 8'h5C, 8'h5B, 8'h5A}, 16'hFFFF, 1'b0);
    test_read({8'h5D, 8'h5C, 8'h5B, 8'h5A}, 16'hFFFF, 1'b1);
    test_rsvd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
